rram_pulse_seq: RTL and testbench

RRAM_PULSE_SEQ -- requirements
Module: rram_pulse_seq

---
 rtl/rram_pulse_seq.sv | 274 +++++++++++++++++++++++++++
 tb/tb_rram_pulse_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rram_pulse_seq.sv
// rram_pulse_seq -- Wishbone-controlled RRAM program/read pulse sequencer.
//
// A CTRL write with start=1 launches one operation (SET, RESET or READ) on
// one of four cells.  The FSM steps SETUP -> PULSE -> SETTLE -> SENSE ->
// CHECK -> DONE.  READ skips the pulse entirely.  DONE raises irq_o for one
// cycle and records done/pass/rd_val/tries in STATUS.
//
// Optional build macro: RRAM_VERIFY_EN
//   defined   : a failed CHECK loops back to SETUP while tries < MAXTRY
//               (program-and-verify).
//   undefined : a single pulse per start; MAXTRY reads as 0.
//
// Register window (ADR_BASE, 16 bytes, word offsets):
//   0x0 CTRL   (W)  op[1:0] cell[3:2] start[8]
//   0x4 TIMING (RW) pw[15:0] settle[23:16]
//   0x8 STATUS (R)  busy[0] done[1] pass[2] rd_val[3] tries[11:4]
//   0xC MAXTRY (RW) [7:0]
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, async active-high reset
//   wbs_*                   Wishbone slave (single-cycle registered ack)
//   cell_sel_o              one-hot cell select
//   wl_en_o/bl_en_o/sl_en_o word/bit/source-line drivers
//   sense_en_o, sense_i     sense-amp enable and async comparator output
//   busy_o, irq_o           busy level, completion pulse
//
// MAX_PW_W must be <= 16 (the pw field is 16 bits wide).
module rram_pulse_seq #(
  parameter logic [31:0] ADR_BASE = 32'h3000_0000,
  parameter int          MAX_PW_W = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  cell_sel_o,
  output logic        wl_en_o,
  output logic        bl_en_o,
  output logic        sl_en_o,
  output logic        sense_en_o,
  input  logic        sense_i,
  output logic        busy_o,
  output logic        irq_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_SETTLE, S_SENSE, S_CHECK, S_DONE
  } state_t;

  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_RST  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  // One counter serves pulse width, settle time and sense length.
  localparam int CNT_W = (MAX_PW_W > 8) ? MAX_PW_W : 8;

  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic [1:0]          op_q;
  logic [1:0]          cell_q;
  logic [MAX_PW_W-1:0] pw_q;
  logic [7:0]          settle_q;
  logic [7:0]          tries;
  logic                done_q, pass_q, rd_val_q;
  logic                sense_s1, sense_s2;
  logic                pass_now;

  // ---------------- Wishbone decode ----------------
  logic       hit, req, wr;
  logic [1:0] off;
  logic       start;

  assign hit = (wbs_adr_i[31:4] == ADR_BASE[31:4]);
  // ack high blocks a second decode of the same request
  assign req = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;
  assign wr  = req & wbs_we_i;
  assign off = wbs_adr_i[3:2];

  // op lives in byte 0 and start in byte 1: both lanes must be written.
  assign start = wr && (off == 2'd0) && wbs_sel_i[0] && wbs_sel_i[1] &&
                 wbs_dat_i[8] && (wbs_dat_i[1:0] != 2'b00) && (state == S_IDLE);

  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:24], wbs_sel_i[3]};

  // ---------------- TIMING / MAXTRY registers ----------------
  logic [15:0] pw_wr;
  always_comb begin
    pw_wr = 16'(pw_q);
    if (wbs_sel_i[0]) pw_wr[7:0]  = wbs_dat_i[7:0];
    if (wbs_sel_i[1]) pw_wr[15:8] = wbs_dat_i[15:8];
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pw_q     <= MAX_PW_W'(10);
      settle_q <= 8'd4;
    end else if (wr && off == 2'd1) begin
      pw_q <= pw_wr[MAX_PW_W-1:0];
      if (wbs_sel_i[2]) settle_q <= wbs_dat_i[23:16];
    end
  end

`ifdef RRAM_VERIFY_EN
  logic [7:0] maxtry_q;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                                  maxtry_q <= 8'd8;
    else if (wr && off == 2'd3 && wbs_sel_i[0])    maxtry_q <= wbs_dat_i[7:0];
  end
`endif

  // ---------------- read mux / ack ----------------
  logic [31:0] rdata;
  always_comb begin
    rdata = 32'h0;
    case (off)
      2'd1: rdata = {8'h00, settle_q, 16'(pw_q)};
      2'd2: rdata = {20'h0, tries, rd_val_q, pass_q, done_q, busy_o};
`ifdef RRAM_VERIFY_EN
      2'd3: rdata = {24'h0, maxtry_q};
`endif
      default: rdata = 32'h0;  // CTRL is write-only
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req && !wbs_we_i) ? rdata : 32'h0;
    end
  end

  // ---------------- sense synchronizer ----------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sense_s1 <= 1'b0;
      sense_s2 <= 1'b0;
    end else begin
      sense_s1 <= sense_i;
      sense_s2 <= sense_s1;
    end
  end

  // ---------------- FSM ----------------
  always_comb begin
    case (op_q)
      OP_SET:  pass_now = rd_val_q;
      OP_RST:  pass_now = ~rd_val_q;
      default: pass_now = 1'b1;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE: if (start) state_n = S_SETUP;
      S_SETUP: begin
        if (op_q == OP_READ) begin
          state_n = S_SENSE;
          cnt_n   = CNT_W'(2);
        end else begin
          // count down to zero: pw=0 still gives one pulse cycle
          state_n = S_PULSE;
          cnt_n   = (pw_q == '0) ? '0 : CNT_W'(pw_q) - CNT_W'(1);
        end
      end
      S_PULSE: begin
        if (cnt == '0) begin
          if (settle_q == 8'd0) begin
            state_n = S_SENSE;
            cnt_n   = CNT_W'(2);
          end else begin
            state_n = S_SETTLE;
            cnt_n   = CNT_W'(settle_q) - CNT_W'(1);
          end
        end else cnt_n = cnt - CNT_W'(1);
      end
      S_SETTLE: begin
        if (cnt == '0) begin
          state_n = S_SENSE;
          cnt_n   = CNT_W'(2);
        end else cnt_n = cnt - CNT_W'(1);
      end
      S_SENSE: begin
        if (cnt == '0) state_n = S_CHECK;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      S_CHECK: begin
`ifdef RRAM_VERIFY_EN
        if (!pass_now && tries < maxtry_q) state_n = S_SETUP;
        else                               state_n = S_DONE;
`else
        state_n = S_DONE;
`endif
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // ---------------- operation / status registers ----------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      op_q     <= 2'b00;
      cell_q   <= 2'b00;
      tries    <= 8'd0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      rd_val_q <= 1'b0;
    end else begin
      if (start) begin
        op_q   <= wbs_dat_i[1:0];
        cell_q <= wbs_dat_i[3:2];
        done_q <= 1'b0;
        tries  <= 8'd0;
      end
      // SETUP always hands off to PULSE for SET/RESET, so count here
      if (state == S_SETUP && op_q != OP_READ && tries != 8'hFF)
        tries <= tries + 8'd1;
      if (state == S_SENSE && cnt == '0) rd_val_q <= sense_s2;
      if (state == S_CHECK)              pass_q   <= pass_now;
      if (state == S_DONE)               done_q   <= 1'b1;
    end
  end

  // ---------------- outputs ----------------
  // Decoded straight from state so reset kills the drivers immediately.
  always_comb begin
    cell_sel_o = 4'b0000;
    wl_en_o    = 1'b0;
    bl_en_o    = 1'b0;
    sl_en_o    = 1'b0;
    sense_en_o = 1'b0;
    irq_o      = 1'b0;
    busy_o     = (state != S_IDLE);
    case (state)
      S_SETUP, S_PULSE: begin
        cell_sel_o = 4'b0001 << cell_q;
        bl_en_o    = (op_q == OP_SET);
        sl_en_o    = (op_q == OP_RST);
        wl_en_o    = (state == S_PULSE);
      end
      S_SETTLE, S_CHECK: cell_sel_o = 4'b0001 << cell_q;
      S_SENSE: begin
        cell_sel_o = 4'b0001 << cell_q;
        sense_en_o = 1'b1;
      end
      S_DONE:  irq_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rram_pulse_seq.sv
module tb_rram_pulse_seq;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w;
  logic        ack;
  logic [31:0] dat_r;
  logic [3:0]  cell_sel;
  logic        wl_en, bl_en, sl_en, sense_en;
  logic        sense;
  logic        busy, irq;

  always #5 clk = ~clk;

  rram_pulse_seq #(.ADR_BASE(BASE), .MAX_PW_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
    .cell_sel_o(cell_sel), .wl_en_o(wl_en), .bl_en_o(bl_en), .sl_en_o(sl_en),
    .sense_en_o(sense_en), .sense_i(sense), .busy_o(busy), .irq_o(irq)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---- output monitor (sampled mid-cycle) ----
  int wl_cyc = 0, wl_rise = 0, bl_cyc = 0, sl_cyc = 0, sen_cyc = 0, irq_cnt = 0, ovl = 0;
  logic       prev_wl = 1'b0;
  logic       wl_to_sense = 1'b0;
  logic [3:0] last_cell = 4'h0;

  always @(negedge clk) begin
    if (wl_en) wl_cyc++;
    if (wl_en && !prev_wl) wl_rise++;
    if (bl_en) bl_cyc++;
    if (sl_en) sl_cyc++;
    if (bl_en && sl_en) ovl++;
    if (sense_en) sen_cyc++;
    if (irq) irq_cnt++;
    if (prev_wl && !wl_en) wl_to_sense = sense_en;
    if (wl_en || sense_en) last_cell = cell_sel;
    prev_wl = wl_en;
  end

  int b_wl, b_rise, b_bl, b_sl, b_sen, b_irq, b_ovl;
  task automatic snap();
    b_wl = wl_cyc; b_rise = wl_rise; b_bl = bl_cyc; b_sl = sl_cyc;
    b_sen = sen_cyc; b_irq = irq_cnt; b_ovl = ovl;
  endtask

  // ---- Wishbone master ----
  task automatic wb_wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = s; adr = BASE + 32'(off); dat_w = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack && n < 8);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("wr_ack_lat", n, 1);
  endtask

  task automatic wb_rd(input logic [3:0] off, output logic [31:0] d);
    int n;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE + 32'(off);
    n = 0;
    do begin @(negedge clk); n++; end while (!ack && n < 8);
    d = dat_r;
    cyc = 1'b0; stb = 1'b0;
    chk("rd_ack_lat", n, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    chk(tag, 32'(n < 3000), 1);
  endtask

  task automatic wait_wl(input string tag);
    int n;
    n = 0;
    while (!wl_en && n < 200) begin @(negedge clk); n++; end
    chk(tag, 32'(wl_en), 1);
  endtask

  logic [31:0] rd;

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'h0; dat_w = 32'h0; sense = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {ack, dat_r, cell_sel, wl_en, bl_en, sl_en, sense_en, busy, irq}, 0);
    rst = 1'b0;

    // reset values
    wb_rd(4'h8, rd); chk("rst_status", rd, 32'h0);
    wb_rd(4'h4, rd); chk("rst_timing", rd, 32'h0004_000A);
`ifdef RRAM_VERIFY_EN
    wb_rd(4'hC, rd); chk("rst_maxtry", rd, 32'h8);
`else
    wb_rd(4'hC, rd); chk("rst_maxtry", rd, 32'h0);
`endif

    // byte-lane write: only settle lane enabled
    wb_wr(4'h4, 32'h00FF_FFFF, 4'b0100);
    wb_rd(4'h4, rd); chk("lane_timing", rd, 32'h00FF_000A);
    wb_wr(4'h4, 32'h0004_000A, 4'hF);

    wb_wr(4'hC, 32'h0000_0003, 4'b0001);
`ifdef RRAM_VERIFY_EN
    wb_rd(4'hC, rd); chk("maxtry_wr", rd, 32'h3);
`else
    wb_rd(4'hC, rd); chk("maxtry_wr", rd, 32'h0);
`endif

    // SET cell 2, sense=1
    sense = 1'b1;
    snap();
    wb_wr(4'h0, 32'h0000_0109, 4'hF);
    wait_idle("set_to");
    chk("set_wl", wl_cyc - b_wl, 10);
    chk("set_rise", wl_rise - b_rise, 1);
    chk("set_sense", sen_cyc - b_sen, 3);
    chk("set_irq", irq_cnt - b_irq, 1);
    chk("set_sl", sl_cyc - b_sl, 0);
    chk("set_bl_on", 32'(bl_cyc != b_bl), 1);
    chk("set_cell", last_cell, 4'b0100);
    wb_rd(4'h8, rd); chk("set_status", rd, 32'h1E);
    wb_rd(4'h0, rd); chk("ctrl_rd0", rd, 32'h0);

    // READ cell 1, sense=0
    sense = 1'b0;
    snap();
    wb_wr(4'h0, 32'h0000_0107, 4'hF);
    wait_idle("read_to");
    chk("read_wl", wl_cyc - b_wl, 0);
    chk("read_sense", sen_cyc - b_sen, 3);
    chk("read_cell", last_cell, 4'b0010);
    chk("read_irq", irq_cnt - b_irq, 1);
    wb_rd(4'h8, rd); chk("read_status", rd, 32'h06);

    // RESET cell 0, sense held 1 (verify never passes)
    sense = 1'b1;
    snap();
    wb_wr(4'h0, 32'h0000_0102, 4'hF);
    wait_idle("reset_to");
    chk("reset_bl", bl_cyc - b_bl, 0);
    chk("reset_sl_on", 32'(sl_cyc != b_sl), 1);
    chk("reset_cell", last_cell, 4'b0001);
    chk("reset_irq", irq_cnt - b_irq, 1);
`ifdef RRAM_VERIFY_EN
    chk("reset_rise", wl_rise - b_rise, 3);
    chk("reset_wl", wl_cyc - b_wl, 30);
    wb_rd(4'h8, rd); chk("reset_status", rd, 32'h3A);
`else
    chk("reset_rise", wl_rise - b_rise, 1);
    chk("reset_wl", wl_cyc - b_wl, 10);
    wb_rd(4'h8, rd); chk("reset_status", rd, 32'h1A);
`endif

    // CTRL start while busy is acked and ignored
    snap();
    wb_wr(4'h0, 32'h0000_0109, 4'hF);
    wb_wr(4'h0, 32'h0000_010E, 4'hF);
    wait_wl("busy_wl_seen");
    chk("busy_cell", cell_sel, 4'b0100);
    chk("busy_drv", {bl_en, sl_en}, 2'b10);
    wait_idle("busy_to");
    chk("busy_wl", wl_cyc - b_wl, 10);
    chk("busy_rise", wl_rise - b_rise, 1);
    chk("busy_irq", irq_cnt - b_irq, 1);
    wb_rd(4'h8, rd); chk("busy_status", rd, 32'h1E);

    // pw=0, settle=0
    wb_wr(4'h4, 32'h0000_0000, 4'b0111);
    snap();
    wb_wr(4'h0, 32'h0000_0101, 4'hF);
    wait_idle("pw0_to");
    chk("pw0_wl", wl_cyc - b_wl, 1);
    chk("pw0_to_sense", 32'(wl_to_sense), 1);
    chk("pw0_sense", sen_cyc - b_sen, 3);
    wb_rd(4'h8, rd); chk("pw0_status", rd, 32'h1E);

    // reset during PULSE
    wb_wr(4'h4, 32'h0007_0005, 4'hF);
    snap();
    wb_wr(4'h0, 32'h0000_0109, 4'hF);
    wait_wl("rst_wl_seen");
    rst = 1'b1;
    #1;
    chk("rst_mid_drv", {cell_sel, wl_en, bl_en, sl_en, sense_en, busy, irq}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_irq", irq_cnt - b_irq, 0);
    wb_rd(4'h8, rd); chk("rst_mid_status", rd, 32'h0);
    wb_rd(4'h4, rd); chk("rst_mid_timing", rd, 32'h0004_000A);

    chk("no_overlap", ovl, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
